fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 4..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 appends an even-parity bit after the data bits.
REQ-003 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 io_enable  input  1  high permits a new frame to start; ignored mid-frame.
REQ-007 io_fifoData  input  8  byte at the head of the upstream byte FIFO; valid while io_fifoEmpty is low.
REQ-008 io_fifoEmpty  input  1  upstream FIFO empty flag.
REQ-009 io_fifoRead  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-010 io_txd  output  1  serial line, idle high, 8N1 (or 8E1/8N2/8E2 per parameters), LSB first.
REQ-011 io_busy  output  1  high while a frame is in progress.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_EN=0.
REQ-013 In IDLE, when io_enable=1 and io_fifoEmpty=0 at an edge, the block SHALL capture io_fifoData into an 8-bit shift register, enter START, and drive io_txd=0 and io_fifoRead=1 from that edge.
REQ-014 io_fifoRead SHALL be high for exactly one cycle per captured byte: the first cycle of START. It SHALL never be high in any other state.
REQ-015 The block SHALL NOT read when io_fifoEmpty=1 or io_enable=0; io_fifoData is sampled only at the capture edge.
REQ-016 START SHALL last CLKS_PER_BIT cycles with io_txd=0.
REQ-017 DATA SHALL drive bits 0..7 of the captured byte, LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index that ends at 7.
REQ-018 PARITY SHALL drive the XOR of the 8 captured bits for CLKS_PER_BIT cycles.
REQ-019 STOP SHALL drive io_txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-020 Total frame length SHALL be (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, measured from the capture edge to the return to IDLE.
REQ-021 io_busy SHALL be high in every state except IDLE.
REQ-022 Back-to-back frames: when the FIFO is non-empty on the IDLE cycle after STOP, the next START SHALL begin on the following edge, so exactly one IDLE cycle separates frames.
REQ-023 Deasserting io_enable mid-frame SHALL NOT truncate the frame; it only blocks the next capture.
REQ-024 The bit-period counter SHALL be 16 bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.

Reset
REQ-025 While reset=1 at an edge, the block SHALL go to IDLE and set io_txd=1, io_fifoRead=0, io_busy=0, and zero the shift register, bit counter and bit index.
REQ-026 Reset mid-frame SHALL abort the frame with no further read strobe; the aborted byte is lost, and io_txd SHALL be high from the next edge.
REQ-027 Reset SHALL take priority over every other condition in the same cycle.

Structure
REQ-028 Shared package fifo_uart_pkg SHALL hold the state enumeration, DATA_BITS=8, and the default CLKS_PER_BIT.
REQ-029 One sub-module, uart_baud_gen, SHALL provide the CLKS_PER_BIT bit-period counter and a one-cycle bit_done tick; it is restarted at the capture edge.

Verification
REQ-030 Reset, then FIFO empty and io_enable=1 for 100 cycles -> io_txd=1, io_fifoRead=0, io_busy=0 throughout.
REQ-031 CLKS_PER_BIT=4, push 0xA5 -> one io_fifoRead pulse; io_txd gives 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; io_busy high for 40 cycles.
REQ-032 PARITY_EN=1, STOP_BITS=2, byte 0x07 -> parity bit 1, stop high for 2*CLKS_PER_BIT cycles, frame of 12*CLKS_PER_BIT cycles.
REQ-033 Push 0x11, 0x22, 0x33 -> three frames in order, each separated by exactly one IDLE cycle, and exactly three read pulses.
REQ-034 io_enable dropped during DATA of byte 0x55 -> frame completes; no new read until io_enable returns high.
REQ-035 Reset asserted in the DATA state -> io_txd=1 and io_busy=0 from the next edge; the next byte is read only after reset is released.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: frame states, data width
// and the default bit period.
package fifo_uart_pkg;

   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and ticks bit_done_o
// on the last cycle of each bit. Restarting forces the count back to zero.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic restart_i,
   input  logic run_i,
   output logic bit_done_o
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // NOTE: the default assignment on the first line keeps this block latch-free.
   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (restart_i || !run_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_done_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and serialises them
// LSB first with optional even parity and one or two stop bits.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_enable,
   input  logic [DATA_BITS-1:0] io_fifoData,
   input  logic                 io_fifoEmpty,
   output logic                 io_fifoRead,
   output logic                 io_txd,
   output logic                 io_busy
);

   tx_state_e            state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [2:0]           bit_idx_q;
   logic                 parity_q;
   logic                 txd_q;
   logic                 read_q;
   logic                 busy_q;

   logic                 capture;
   logic                 bit_done;

   assign capture = (state_q == IDLE) && io_enable && !io_fifoEmpty;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk        (clk),
      .reset      (reset),
      .restart_i  (capture),
      .run_i      (busy_q),
      .bit_done_o (bit_done)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every branch
   // below reads the pre-edge values of the registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         parity_q  <= 1'b0;
         txd_q     <= 1'b1;
         read_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         read_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (capture) begin
                  state_q   <= START;
                  shift_q   <= io_fifoData;
                  parity_q  <= ^io_fifoData;
                  bit_idx_q <= '0;
                  txd_q     <= 1'b0;
                  read_q    <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            START: begin
               if (bit_done) begin
                  state_q <= DATA;
                  txd_q   <= shift_q[0];
               end
            end
            DATA: begin
               if (bit_done) begin
                  shift_q <= shift_q >> 1;
                  if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                     bit_idx_q <= '0;
                     if (PARITY_EN != 0) begin
                        state_q <= PARITY;
                        txd_q   <= parity_q;
                     end else begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     txd_q     <= shift_q[1];
                  end
               end
            end
            PARITY: begin
               if (bit_done) begin
                  state_q <= STOP;
                  txd_q   <= 1'b1;
               end
            end
            STOP: begin
               // bit_idx_q is reused here to count stop bits.
               if (bit_done) begin
                  if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                     state_q   <= IDLE;
                     bit_idx_q <= '0;
                     busy_q    <= 1'b0;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               txd_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign io_fifoRead = read_q;
   assign io_txd      = txd_q;
   assign io_busy     = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 at 4 clk/bit, 8E2 at 5 clk/bit)
// compared every cycle against a frame-level model, plus literal frame checks.
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       io_enable = 1'b0;
   logic [1:0] empty = 2'b11;
   logic [1:0] rd;
   logic [1:0] txd;
   logic [1:0] busy;
   logic [7:0] fdata [2] = '{8'h00, 8'h00};

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut_a (
      .clk          (clk),
      .reset        (reset),
      .io_enable    (io_enable),
      .io_fifoData  (fdata[0]),
      .io_fifoEmpty (empty[0]),
      .io_fifoRead  (rd[0]),
      .io_txd       (txd[0]),
      .io_busy      (busy[0])
   );

   fifo_uart_tx #(.CLKS_PER_BIT(5), .PARITY_EN(1), .STOP_BITS(2)) u_dut_b (
      .clk          (clk),
      .reset        (reset),
      .io_enable    (io_enable),
      .io_fifoData  (fdata[1]),
      .io_fifoEmpty (empty[1]),
      .io_fifoRead  (rd[1]),
      .io_txd       (txd[1]),
      .io_busy      (busy[1])
   );

   function automatic int cpb(input int d);
      return (d == 0) ? 4 : 5;
   endfunction

   function automatic int par(input int d);
      return (d == 0) ? 0 : 1;
   endfunction

   function automatic int stops(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic int flen(input int d);
      return (1 + 8 + par(d) + stops(d)) * cpb(d);
   endfunction

   // Serial bit sequence of one frame; positions past the data/parity are stop (1).
   function automatic logic [11:0] frame_bits(input int d, input logic [7:0] b);
      logic [11:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1 + i] = b[i];
      if (par(d) != 0) f[9] = ^b;
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic push(input int d, input logic [7:0] b);
      if (d == 0) q0.push_back(b);
      else        q1.push_back(b);
   endtask

   // Reference model: a frame is "active" for flen cycles after a capture edge.
   bit          model_valid = 1'b0;
   bit          act_m [2]   = '{1'b0, 1'b0};
   int          k_m   [2]   = '{0, 0};
   logic [11:0] fb_m  [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            act_m[d] = 1'b0;
            k_m[d]   = 0;
         end else if (act_m[d]) begin
            if (k_m[d] == flen(d) - 1) act_m[d] = 1'b0;
            else                       k_m[d]   = k_m[d] + 1;
         end else if (io_enable && !empty[d]) begin
            act_m[d] = 1'b1;
            k_m[d]   = 0;
            fb_m[d]  = frame_bits(d, fdata[d]);
         end
      end
      if (reset) model_valid = 1'b1;
   end

   // Per-cycle compare, then the upstream FIFO pops on the strobe and re-presents its head.
   always @(negedge clk) begin
      if (model_valid) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("busy%0d", d), busy[d], act_m[d]);
            check($sformatf("read%0d", d), rd[d], act_m[d] && (k_m[d] == 0));
            check($sformatf("txd%0d", d), txd[d],
                  act_m[d] ? fb_m[d][k_m[d] / cpb(d)] : 1'b1);
         end
      end
      if (rd[0] === 1'b1 && q0.size() > 0) void'(q0.pop_front());
      if (rd[1] === 1'b1 && q1.size() > 0) void'(q1.pop_front());
      empty[0] = (q0.size() == 0);
      empty[1] = (q1.size() == 0);
      fdata[0] = empty[0] ? 8'h00 : q0[0];
      fdata[1] = empty[1] ? 8'h00 : q1[0];
   end

   // Waits for a frame, samples each bit mid-period, measures busy length and read pulses.
   task automatic capture_frame(input int d, output int gap, output int blen,
                                output logic [11:0] bits, output int reads);
      gap   = 0;
      blen  = 0;
      bits  = '1;
      reads = 0;
      while (busy[d] !== 1'b1 && gap < 400) begin
         @(negedge clk);
         gap++;
      end
      if (busy[d] !== 1'b1) begin
         check($sformatf("frame_start%0d", d), busy[d], 1);
         return;
      end
      while (busy[d] === 1'b1 && blen < 400) begin
         if ((blen % cpb(d)) == cpb(d) / 2 && (blen / cpb(d)) < 12) bits[blen / cpb(d)] = txd[d];
         if (rd[d] === 1'b1) reads++;
         blen++;
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   int          gap0, gap1, bl0, bl1, r0, r1, bad, w;
   logic [11:0] b0, b1;
   logic [7:0]  bytes3 [3] = '{8'h11, 8'h22, 8'h33};

   initial begin
      reset     = 1'b1;
      io_enable = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_txd", txd, 2'b11);
      check("reset_busy", busy, 2'b00);
      check("reset_read", rd, 2'b00);
      reset = 1'b0;

      // Empty FIFO with enable high: the line must stay idle.
      io_enable = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (txd !== 2'b11 || rd !== 2'b00 || busy !== 2'b00) bad++;
      end
      check("empty_idle_cycles_bad", bad, 0);

      // 0xA5 on 8N1/4 and 0x07 on 8E2/5 in parallel.
      push(0, 8'hA5);
      push(1, 8'h07);
      fork
         capture_frame(0, gap0, bl0, b0, r0);
         capture_frame(1, gap1, bl1, b1, r1);
      join
      check("a5_bits", {22'd0, b0[9:0]}, 32'h34A);
      check("a5_busy_len", bl0, 40);
      check("a5_reads", r0, 1);
      check("07_bits", {20'd0, b1}, 32'hE0E);
      check("07_busy_len", bl1, 60);
      check("07_reads", r1, 1);

      // Back-to-back frames with exactly one idle cycle between them.
      for (int i = 0; i < 3; i++) push(0, bytes3[i]);
      for (int i = 0; i < 3; i++) begin
         capture_frame(0, gap0, bl0, b0, r0);
         check($sformatf("b2b_bits%0d", i), {22'd0, b0[9:0]}, {22'd0, 1'b1, bytes3[i], 1'b0});
         check($sformatf("b2b_reads%0d", i), r0, 1);
         check($sformatf("b2b_len%0d", i), bl0, 40);
         if (i > 0) check($sformatf("b2b_gap%0d", i), gap0, 1);
      end

      // Enable dropped mid-DATA: frame completes, next byte waits for enable.
      push(0, 8'h55);
      push(0, 8'h66);
      fork
         capture_frame(0, gap0, bl0, b0, r0);
         begin
            w = 0;
            while (busy[0] !== 1'b1 && w < 400) begin
               @(negedge clk);
               w++;
            end
            repeat (10) @(negedge clk);
            io_enable = 1'b0;
         end
      join
      check("en_drop_bits", {22'd0, b0[9:0]}, {22'd0, 1'b1, 8'h55, 1'b0});
      check("en_drop_len", bl0, 40);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (rd[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
      end
      check("en_low_no_read", bad, 0);
      io_enable = 1'b1;
      capture_frame(0, gap0, bl0, b0, r0);
      check("en_back_bits", {22'd0, b0[9:0]}, {22'd0, 1'b1, 8'h66, 1'b0});
      check("en_back_reads", r0, 1);

      // Reset during DATA aborts the frame; the next byte goes out after release.
      push(0, 8'h99);
      push(0, 8'h5A);
      w = 0;
      while (busy[0] !== 1'b1 && w < 400) begin
         @(negedge clk);
         w++;
      end
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_txd", txd[0], 1);
      check("rst_mid_busy", busy[0], 0);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (rd[0] !== 1'b0) bad++;
      end
      check("rst_no_read", bad, 0);
      reset = 1'b0;
      capture_frame(0, gap0, bl0, b0, r0);
      check("rst_next_bits", {22'd0, b0[9:0]}, {22'd0, 1'b1, 8'h5A, 1'b0});
      check("rst_next_reads", r0, 1);

      // Randomised traffic, enable gating and occasional resets.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if ($urandom_range(0, 29) == 0 && q0.size() < 6) push(0, 8'($urandom));
         if ($urandom_range(0, 39) == 0 && q1.size() < 6) push(1, 8'($urandom));
         io_enable = ($urandom_range(0, 9) != 0);
         reset     = ($urandom_range(0, 799) == 0);
      end
      reset     = 1'b0;
      io_enable = 1'b1;
      w = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && busy === 2'b00) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check("drain_q0", q0.size(), 0);
      check("drain_q1", q1.size(), 0);
      check("drain_busy", busy, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
